fpu_seq_sub: RTL and testbench

- Multi-cycle IEEE-754-style floating-point subtractor: DIFF = A - B.
- Complements the existing single-cycle combinational adder. Used where area matters more than latency.
- Aligns one bit per cycle and normalizes one bit per cycle under a state machine.
- Valid/ready handshakes on input and output; one operation in flight.

---
 rtl/fpu_seq_sub_if.sv | 29 ++
 rtl/fpu_seq_sub.sv | 181 ++++++++++++++++++
 tb/tb_fpu_seq_sub.sv | 237 +++++++++++++++++++++++
 3 files changed

// File: rtl/fpu_seq_sub_if.sv
// Operand/result handshake bundle for fpu_seq_sub; op exists only with FPU_SEQ_ADDSUB_EN.
// The master drives operands and out_ready; the slave returns in_ready, out_valid, DIFF and busy.
interface fpu_seq_sub_if #(
    parameter int total_size = 32
);
    logic                  in_valid;
    logic                  in_ready;
    logic [total_size-1:0] A;
    logic [total_size-1:0] B;
`ifdef FPU_SEQ_ADDSUB_EN
    logic                  op;
`endif
    logic                  out_valid;
    logic                  out_ready;
    logic [total_size-1:0] DIFF;
    logic                  busy;

`ifdef FPU_SEQ_ADDSUB_EN
    modport master (output in_valid, A, B, op, out_ready,
                    input  in_ready, out_valid, DIFF, busy);
    modport slave  (input  in_valid, A, B, op, out_ready,
                    output in_ready, out_valid, DIFF, busy);
`else
    modport master (output in_valid, A, B, out_ready,
                    input  in_ready, out_valid, DIFF, busy);
    modport slave  (input  in_valid, A, B, out_ready,
                    output in_ready, out_valid, DIFF, busy);
`endif
endinterface

// File: rtl/fpu_seq_sub.sv
// Sequential FP subtractor DIFF=A-B (A+B/A-B via op when FPU_SEQ_ADDSUB_EN); latency (diff+1)+1+(shifts+1)+1 edges, specials 1.
// Backpressure: DONE holds DIFF/out_valid until out_ready; in_ready only in IDLE, one operation in flight.
module fpu_seq_sub #(
    parameter int M_size     = 23,
    parameter int E_size     = 8,
    parameter int total_size = 1 + E_size + M_size
) (
    input  logic         clk,
    input  logic         rst_n,
    fpu_seq_sub_if.slave io_bus
);
    localparam int MW = M_size + 2;
    localparam logic [E_size-1:0] EXP_ONES = '1;

    typedef enum logic [2:0] {S_IDLE, S_ALIGN, S_ADD, S_NORM, S_DONE} state_t;

    state_t                r_state;
    logic                  r_sign_big;
    logic                  r_sign_sml;
    logic                  r_sign_res;
    logic [E_size-1:0]     r_exp;
    logic [E_size-1:0]     r_diff;
    logic [MW-1:0]         r_mant_big;
    logic [MW-1:0]         r_mant_sml;
    logic [total_size-1:0] r_dat;
    logic                  r_in_rdy;
    logic                  r_out_vld;
    logic                  r_busy;

    logic                  w_sign_a;
    logic                  w_sign_b;
    logic [E_size-1:0]     w_exp_a;
    logic [E_size-1:0]     w_exp_b;
    logic [M_size-1:0]     w_frac_a;
    logic [M_size-1:0]     w_frac_b;
    logic [MW-1:0]         w_mant_a;
    logic [MW-1:0]         w_mant_b;
    logic                  w_spec_a;
    logic                  w_spec_b;
    logic                  w_spec_nan;
    logic                  w_spec_sign;
    logic                  w_a_big;
    logic [total_size-1:0] w_spec_dat;
    logic [MW-1:0]         w_sum;
    logic [E_size-1:0]     w_exp_inc;
    logic [E_size-1:0]     w_exp_dec;

    always_comb begin
        w_sign_a = io_bus.A[total_size-1];
`ifdef FPU_SEQ_ADDSUB_EN
        w_sign_b = io_bus.B[total_size-1] ^ io_bus.op;
`else
        w_sign_b = ~io_bus.B[total_size-1];
`endif
        w_exp_a  = io_bus.A[total_size-2 -: E_size];
        w_exp_b  = io_bus.B[total_size-2 -: E_size];
        w_frac_a = io_bus.A[M_size-1:0];
        w_frac_b = io_bus.B[M_size-1:0];
        // Exponent zero flushes the operand to zero: no hidden bit.
        w_mant_a = (w_exp_a == '0) ? '0 : {1'b0, 1'b1, w_frac_a};
        w_mant_b = (w_exp_b == '0) ? '0 : {1'b0, 1'b1, w_frac_b};
        w_spec_a = &w_exp_a;
        w_spec_b = &w_exp_b;
        w_a_big  = (w_exp_a >= w_exp_b);
        // Inf with opposite effective signs cancels to NaN.
        w_spec_nan  = (w_spec_a & (|w_frac_a)) | (w_spec_b & (|w_frac_b))
                    | (w_spec_a & w_spec_b & (w_sign_a != w_sign_b));
        w_spec_sign = w_spec_a ? w_sign_a : w_sign_b;
        w_spec_dat  = {w_spec_sign, EXP_ONES, {(M_size-1){1'b0}}, w_spec_nan};
        w_sum       = r_mant_big + r_mant_sml;
        w_exp_inc   = r_exp + E_size'(1);
        w_exp_dec   = r_exp - E_size'(1);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_sign_big <= 1'b0;
            r_sign_sml <= 1'b0;
            r_sign_res <= 1'b0;
            r_exp      <= '0;
            r_diff     <= '0;
            r_mant_big <= '0;
            r_mant_sml <= '0;
            r_dat      <= '0;
            r_in_rdy   <= 1'b1;
            r_out_vld  <= 1'b0;
            r_busy     <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (io_bus.in_valid) begin
                        r_in_rdy <= 1'b0;
                        r_busy   <= 1'b1;
                        if (w_spec_a | w_spec_b) begin
                            r_dat     <= w_spec_dat;
                            r_out_vld <= 1'b1;
                            r_state   <= S_DONE;
                        end else begin
                            r_exp      <= w_a_big ? w_exp_a : w_exp_b;
                            r_diff     <= w_a_big ? (w_exp_a - w_exp_b) : (w_exp_b - w_exp_a);
                            r_mant_big <= w_a_big ? w_mant_a : w_mant_b;
                            r_mant_sml <= w_a_big ? w_mant_b : w_mant_a;
                            r_sign_big <= w_a_big ? w_sign_a : w_sign_b;
                            r_sign_sml <= w_a_big ? w_sign_b : w_sign_a;
                            r_state    <= S_ALIGN;
                        end
                    end
                end
                S_ALIGN: begin
                    if (r_diff == '0) begin
                        r_state <= S_ADD;
                    end else if (r_diff > E_size'(M_size + 1)) begin
                        r_mant_sml <= '0;
                        r_diff     <= '0;
                    end else begin
                        r_mant_sml <= r_mant_sml >> 1;
                        r_diff     <= r_diff - E_size'(1);
                    end
                end
                S_ADD: begin
                    // r_mant_big carries the result magnitude into NORM.
                    if (r_sign_big == r_sign_sml) begin
                        r_mant_big <= w_sum;
                        r_sign_res <= r_sign_big;
                        r_state    <= S_NORM;
                    end else if (r_mant_big == r_mant_sml) begin
                        r_dat     <= '0;
                        r_out_vld <= 1'b1;
                        r_state   <= S_DONE;
                    end else if (r_mant_big > r_mant_sml) begin
                        r_mant_big <= r_mant_big - r_mant_sml;
                        r_sign_res <= r_sign_big;
                        r_state    <= S_NORM;
                    end else begin
                        r_mant_big <= r_mant_sml - r_mant_big;
                        r_sign_res <= r_sign_sml;
                        r_state    <= S_NORM;
                    end
                end
                S_NORM: begin
                    if (r_mant_big[MW-1]) begin
                        if (w_exp_inc == EXP_ONES)
                            r_dat <= {r_sign_res, EXP_ONES, {M_size{1'b0}}};
                        else
                            r_dat <= {r_sign_res, w_exp_inc, r_mant_big[M_size:1]};
                        r_out_vld <= 1'b1;
                        r_state   <= S_DONE;
                    end else if (!r_mant_big[M_size]) begin
                        if (w_exp_dec == '0) begin
                            r_dat     <= {r_sign_res, {(total_size-1){1'b0}}};
                            r_out_vld <= 1'b1;
                            r_state   <= S_DONE;
                        end else begin
                            r_mant_big <= r_mant_big << 1;
                            r_exp      <= w_exp_dec;
                        end
                    end else begin
                        r_dat     <= {r_sign_res, r_exp, r_mant_big[M_size-1:0]};
                        r_out_vld <= 1'b1;
                        r_state   <= S_DONE;
                    end
                end
                S_DONE: begin
                    if (io_bus.out_ready) begin
                        r_out_vld <= 1'b0;
                        r_in_rdy  <= 1'b1;
                        r_busy    <= 1'b0;
                        r_state   <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign io_bus.in_ready  = r_in_rdy;
    assign io_bus.out_valid = r_out_vld;
    assign io_bus.DIFF      = r_dat;
    assign io_bus.busy      = r_busy;
endmodule

// File: tb/tb_fpu_seq_sub.sv
// Scoreboard bench for fpu_seq_sub: a reference model predicts DIFF and accept-to-out_valid latency.
// Covers reset, alignment/normalisation paths, specials, backpressure and mid-operation reset.
module tb_fpu_seq_sub;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    fpu_seq_sub_if #(.total_size(32)) bus ();

    fpu_seq_sub #(.M_size(23), .E_size(8), .total_size(32)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .io_bus (bus)
    );

    typedef struct {
        logic [31:0] dat;
        int          lat;
        string       tag;
    } exp_t;

    exp_t sb_q[$];
    int   n_chk  = 0;
    int   n_pass = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_chk++;
        if (got === want) n_pass++;
        else $display("FAIL %s: got %h want %h", tag, got, want);
    endtask

    // Truncating reference: 24-bit magnitudes, no guard bits, flush-to-zero.
    function automatic void model(input logic [31:0] a, input logic [31:0] b, input logic sub,
                                  output logic [31:0] r, output int lat);
        int     ea, eb, ebig, d, al, nc, e;
        longint ma, mb, mbig, msml, m;
        bit     sa, sb, sbig, ssml, s, nan;
        sa = a[31];
        sb = b[31] ^ sub;
        ea = int'(a[30:23]);
        eb = int'(b[30:23]);
        if (ea == 255 || eb == 255) begin
            nan = (ea == 255 && a[22:0] != 0) || (eb == 255 && b[22:0] != 0)
                  || (ea == 255 && eb == 255 && sa != sb);
            r   = {(ea == 255) ? sa : sb, 8'hFF, 22'd0, nan};
            lat = 1;
            return;
        end
        ma = (ea == 0) ? 0 : (longint'(a[22:0]) + 64'h800000);
        mb = (eb == 0) ? 0 : (longint'(b[22:0]) + 64'h800000);
        if (ea >= eb) begin
            mbig = ma; sbig = sa; ebig = ea; msml = mb; ssml = sb; d = ea - eb;
        end else begin
            mbig = mb; sbig = sb; ebig = eb; msml = ma; ssml = sa; d = eb - ea;
        end
        al   = (d > 24) ? 2 : d + 1;
        msml = (d > 24) ? 0 : (msml >> d);
        if (sbig == ssml) begin
            m = mbig + msml; s = sbig;
        end else if (mbig == msml) begin
            r   = 32'd0;
            lat = al + 2;
            return;
        end else if (mbig > msml) begin
            m = mbig - msml; s = sbig;
        end else begin
            m = msml - mbig; s = ssml;
        end
        e  = ebig;
        nc = 1;
        if (m >= 64'h1000000) begin
            m = m >> 1;
            e = e + 1;
            if (e == 255) m = 0;
        end else begin
            while (m < 64'h800000) begin
                if (e == 1) begin
                    e = 0; m = 0;
                    break;
                end
                m  = m << 1;
                e  = e - 1;
                nc = nc + 1;
            end
        end
        r   = {s, e[7:0], m[22:0]};
        lat = al + 1 + nc + 1;
    endfunction

    // Drive one operation and wait for out_valid; returns edges counted from the accept edge.
    task automatic start_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                            input logic op, output int cyc);
        exp_t e;
        logic [31:0] r;
        int lat;
        model(a, b, op, r, lat);
        bus.A = a;
        bus.B = b;
`ifdef FPU_SEQ_ADDSUB_EN
        bus.op = op;
`endif
        bus.in_valid = 1'b1;
        cyc = 0;
        while (!bus.in_ready && cyc < 100) begin
            @(posedge clk); #1;
            cyc++;
        end
        chk({tag, " in_ready"}, 32'(bus.in_ready), 32'd1);
        @(posedge clk);
        e.dat = r; e.lat = lat; e.tag = tag;
        sb_q.push_back(e);
        #1;
        bus.in_valid = 1'b0;
        cyc = 1;
        while (!bus.out_valid && cyc < 200) begin
            chk({tag, " busy"}, {bus.busy, bus.in_ready}, 32'b10);
            @(posedge clk); #1;
            cyc++;
        end
    endtask

    task automatic finish_op(input int cyc);
        exp_t e;
        if (sb_q.size() == 0) begin
            chk("scoreboard underflow", 32'd1, 32'd0);
            return;
        end
        e = sb_q.pop_front();
        chk({e.tag, " out_valid"}, 32'(bus.out_valid), 32'd1);
        chk({e.tag, " DIFF"}, bus.DIFF, e.dat);
        chk({e.tag, " latency"}, 32'(cyc), 32'(e.lat));
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
        chk({e.tag, " idle"}, {bus.out_valid, bus.in_ready, bus.busy}, 32'b010);
    endtask

    task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b, input logic op);
        int cyc;
        start_op(tag, a, b, op, cyc);
        finish_op(cyc);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int cyc;
        int spurious;
        logic [31:0] ra, rb;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        bus.A         = '0;
        bus.B         = '0;
`ifdef FPU_SEQ_ADDSUB_EN
        bus.op        = 1'b1;
`endif
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset", {bus.in_ready, bus.out_valid, bus.busy}, 32'b100);
        chk("reset DIFF", bus.DIFF, 32'd0);
        rst_n = 1'b1;

        run_op("3-1", 32'h40400000, 32'h3F800000, 1'b1);
        run_op("1-1", 32'h3F800000, 32'h3F800000, 1'b1);
        run_op("1-(-1)", 32'h3F800000, 32'hBF800000, 1'b1);
        // Without guard bits the 1.0 is shifted out completely (diff 24).
        run_op("2^24-1", 32'h4B800000, 32'h3F800000, 1'b1);
        // Near-cancellation: 23 left shifts in NORM.
        run_op("cancel", 32'h3F800000, 32'h3F7FFFFF, 1'b1);
        run_op("big diff", 32'h3F800000, 32'h30800000, 1'b1);
        run_op("inf-1", 32'h7F800000, 32'h3F800000, 1'b1);
        run_op("inf-inf", 32'h7F800000, 32'h7F800000, 1'b1);
        run_op("inf-(-inf)", 32'h7F800000, 32'hFF800000, 1'b1);
        run_op("1-inf", 32'h3F800000, 32'h7F800000, 1'b1);
        run_op("nan-1", 32'h7FC00000, 32'h3F800000, 1'b1);
        run_op("overflow", 32'h7F7FFFFF, 32'hFF7FFFFF, 1'b1);
        run_op("underflow", 32'h00800000, 32'h00800001, 1'b1);
        run_op("zero-1", 32'h00000000, 32'h3F800000, 1'b1);
        for (int i = 0; i < 8; i++) begin
            ra = {1'($urandom), 8'($urandom_range(110, 140)), 23'($urandom)};
            rb = {1'($urandom), 8'($urandom_range(110, 140)), 23'($urandom)};
            run_op($sformatf("rand%0d", i), ra, rb, 1'b1);
        end
`ifdef FPU_SEQ_ADDSUB_EN
        run_op("3+1 op0", 32'h40400000, 32'h3F800000, 1'b0);
        run_op("3-1 op1", 32'h40400000, 32'h3F800000, 1'b1);
`endif

        // Backpressure: result held, new operands ignored.
        start_op("bp", 32'h40400000, 32'h3F800000, 1'b1, cyc);
        bus.A = 32'h41200000;
        bus.B = 32'h3F800000;
        bus.in_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            chk("bp hold", {bus.out_valid, bus.in_ready, bus.busy}, 32'b101);
            chk("bp DIFF", bus.DIFF, sb_q[0].dat);
        end
        bus.in_valid = 1'b0;
        finish_op(cyc);

        // Reset during ALIGN aborts the operation.
        bus.A = 32'h4B800000;
        bus.B = 32'h3F800000;
        bus.in_valid = 1'b1;
        cyc = 0;
        while (!bus.in_ready && cyc < 100) begin
            @(posedge clk); #1;
            cyc++;
        end
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        @(posedge clk); #1;
        chk("pre-reset busy", 32'(bus.busy), 32'd1);
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        chk("mid reset", {bus.in_ready, bus.out_valid, bus.busy}, 32'b100);
        chk("mid reset DIFF", bus.DIFF, 32'd0);
        spurious = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            if (bus.out_valid) spurious++;
        end
        chk("no spurious out_valid", 32'(spurious), 32'd0);
        run_op("after reset", 32'h40400000, 32'h3F800000, 1'b1);

        chk("scoreboard empty", 32'(sb_q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
